// File: rtl/iir_biquad_mc_pkg.sv
// Shared types and Q-format helpers for the multi-channel biquad section.
package iir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} coef_idx_e;

  localparam int NUM_TAPS = 5;
  localparam int DEF_DW   = 16;
  localparam int DEF_IW   = 18;
  localparam int DEF_CW   = 18;

  // Unity gain in a Q2.(cw-2) coefficient.
  function automatic longint coef_one(input int cw);
    return longint'(1) <<< (cw - 2);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/iir_biquad_mc_mac_sat_acc.sv
// Shared saturating MAC: signed product accumulated at full precision, then rounded to IW and clipped.
module mac_sat_acc
  import iir_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int CW = DEF_CW
) (
  input  logic                 clk_i,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_sub,
  input  logic signed [IW-1:0] i_a,
  input  logic signed [CW-1:0] i_b,
  output logic signed [IW-1:0] o_y,
  output logic                 o_sat
);

  localparam int PW    = IW + CW;
  localparam int ACC_W = IW + CW + 3;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(IW));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(IW));
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(longint'(1) <<< (CW - 3));

  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] r_acc;

  // Round half up, then drop the coefficient fraction bits.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a + RND;
    return t >>> (CW - 2);
  endfunction

  function automatic logic signed [IW-1:0] saturate(input  logic signed [ACC_W-1:0] v,
                                                    output logic                    clip);
    clip = 1'b0;
    if (v > ACC_MAX) begin
      clip = 1'b1;
      return IW'(ACC_MAX);
    end
    if (v < ACC_MIN) begin
      clip = 1'b1;
      return IW'(ACC_MIN);
    end
    return IW'(v);
  endfunction

  assign w_prod = PW'(i_a) * PW'(i_b);
  assign w_term = i_sub ? -ACC_W'(w_prod) : ACC_W'(w_prod);

  // Accumulator stage
  always_ff @(posedge clk_i) begin
    if (i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= r_acc + w_term;
  end

  // Round / saturate stage (combinational off the accumulator)
  always_comb begin
    logic clip;
    o_y   = saturate(round_shift(r_acc), clip);
    o_sat = clip;
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed direct-form-I biquad for NUM_CH interleaved channels with run-time coefficients.
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DW     = DEF_DW,
  parameter int IW     = DEF_IW,
  parameter int CW     = DEF_CW,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [CHW-1:0]       in_ch_i,
  input  logic signed [DW-1:0] data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CHW-1:0]       out_ch_o,
  output logic signed [DW-1:0] data_o,
  output logic                 sat_o,
  input  logic                 cfg_we_i,
  output logic                 cfg_ready_o,
  input  logic [CHW-1:0]       cfg_ch_i,
  input  logic [2:0]           cfg_idx_i,
  input  logic signed [CW-1:0] cfg_data_i
);

  localparam logic signed [CW-1:0] ONE = CW'(coef_one(CW));

  state_e r_state, w_state_d;
  logic [2:0]           r_cnt;
  logic [CHW-1:0]       r_ch;
  logic signed [IW-1:0] r_x;
  logic signed [CW-1:0] r_coef [NUM_CH][NUM_TAPS];
  logic signed [IW-1:0] r_x1 [NUM_CH];
  logic signed [IW-1:0] r_x2 [NUM_CH];
  logic signed [IW-1:0] r_y1 [NUM_CH];
  logic signed [IW-1:0] r_y2 [NUM_CH];

  logic                 w_accept, w_start, w_acc_en, w_enter_out, w_cfg_wr;
  logic                 w_in_ch_ok, w_cfg_ch_ok, w_sub, w_sat;
  logic signed [IW-1:0] w_x_ext, w_op_a, w_y;
  logic signed [CW-1:0] w_op_b;

  assign in_ready_o  = (r_state == IDLE);
  assign cfg_ready_o = (r_state == IDLE);
  assign out_valid_o = (r_state == OUT);
  assign w_in_ch_ok  = (32'(in_ch_i) < NUM_CH);
  assign w_cfg_ch_ok = (32'(cfg_ch_i) < NUM_CH);
  assign w_cfg_wr    = cfg_we_i & cfg_ready_o & w_cfg_ch_ok;
  assign w_x_ext     = IW'(data_i) <<< (IW - DW);

  // Control: r_cnt 0..4 issues one tap per cycle, r_cnt 5 lets the rounded result settle.
  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_acc_en    = 1'b0;
    w_enter_out = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid_i) begin
          w_accept = 1'b1;
          if (w_in_ch_ok) begin
            w_start   = 1'b1;
            w_state_d = MAC;
          end
        end
      end
      MAC: begin
        w_acc_en = (r_cnt < 3'd5);
        if (r_cnt == 3'd5) begin
          w_enter_out = 1'b1;
          w_state_d   = OUT;
        end
      end
      OUT:     if (out_ready_i) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    if (clear_i) begin
      w_state_d   = IDLE;
      w_accept    = 1'b0;
      w_start     = 1'b0;
      w_acc_en    = 1'b0;
      w_enter_out = 1'b0;
    end
  end

  always_comb begin
    w_op_a = r_x;
    w_op_b = r_coef[r_ch][0];
    w_sub  = 1'b0;
    case (r_cnt)
      3'd1: begin w_op_a = r_x1[r_ch]; w_op_b = r_coef[r_ch][1]; end
      3'd2: begin w_op_a = r_x2[r_ch]; w_op_b = r_coef[r_ch][2]; end
      3'd3: begin w_op_a = r_y1[r_ch]; w_op_b = r_coef[r_ch][3]; w_sub = 1'b1; end
      3'd4: begin w_op_a = r_y2[r_ch]; w_op_b = r_coef[r_ch][4]; w_sub = 1'b1; end
      default: ;
    endcase
  end

  mac_sat_acc #(.IW(IW), .CW(CW)) u_mac (
    .clk_i (clk_i),
    .i_clr (w_start),
    .i_en  (w_acc_en),
    .i_sub (w_sub),
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .o_y   (w_y),
    .o_sat (w_sat)
  );

  // Input sample register (data only, no reset needed)
  always_ff @(posedge clk_i) begin
    if (w_accept) r_x <= w_x_ext;
  end

  // State, output, history and coefficient registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ch     <= '0;
      out_ch_o <= '0;
      data_o   <= '0;
      sat_o    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_x1[c] <= '0;
        r_x2[c] <= '0;
        r_y1[c] <= '0;
        r_y2[c] <= '0;
        for (int k = 0; k < NUM_TAPS; k++)
          r_coef[c][k] <= (k == 0) ? ONE : '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_cnt <= '0;
        r_ch  <= in_ch_i;
      end else if (r_state == MAC) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_enter_out) begin
        out_ch_o   <= r_ch;
        data_o     <= DW'(w_y >>> (IW - DW));
        sat_o      <= w_sat;
        r_x1[r_ch] <= r_x;
        r_x2[r_ch] <= r_x1[r_ch];
        r_y1[r_ch] <= w_y;
        r_y2[r_ch] <= r_y1[r_ch];
      end
      if (clear_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_x1[c] <= '0;
          r_x2[c] <= '0;
          r_y1[c] <= '0;
          r_y2[c] <= '0;
        end
      end
      if (w_cfg_wr) begin
        case (coef_idx_e'(cfg_idx_i))
          B0:      r_coef[cfg_ch_i][0] <= cfg_data_i;
          B1:      r_coef[cfg_ch_i][1] <= cfg_data_i;
          B2:      r_coef[cfg_ch_i][2] <= cfg_data_i;
          A1:      r_coef[cfg_ch_i][3] <= cfg_data_i;
          A2:      r_coef[cfg_ch_i][4] <= cfg_data_i;
          default: ;
        endcase
      end
    end
  end

endmodule
